// File: rtl/jtframe_db15_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_db15_pkg
//  Description : Shared types and constants for the DB15 SNAC joystick reader.
//                Holds the reader state encoding, the bit position of each
//                control within one player's 12-bit serial word, and the
//                per-player decoded record.
//  Revision    : 1.0 - initial release
// ============================================================================
package jtframe_db15_pkg;

    // Reader states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } db15_state_t;

    // Bits per player in the serial stream
    localparam int PLAYER_BITS = 12;

    // Position of each control within a player's word, in arrival order
    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int B1    = 4;
    localparam int B2    = 5;
    localparam int B3    = 6;
    localparam int B4    = 7;
    localparam int B5    = 8;
    localparam int B6    = 9;
    localparam int START = 10;
    localparam int COIN  = 11;

    // One player's controls in frame order (all active high)
    typedef struct packed {
        logic       coin;
        logic       start;
        logic [9:0] joy;    // bit0 right, bit1 left, bit2 down, bit3 up, 9:4 b6..b1
    } db15_player_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_db15_map.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_db15_map
//  Description : Combinational reorder of one player's captured serial word
//                (already inverted to active high) into frame joystick order.
//  Ports       : raw_i  [11:0]  captured word, bit n = n-th bit received
//                map_o          {coin, start, joy[9:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_db15_map
    import jtframe_db15_pkg::*;
(
    input  logic [PLAYER_BITS-1:0] raw_i,
    output db15_player_t           map_o
);

    always_comb begin
        map_o.joy[0] = raw_i[RIGHT];
        map_o.joy[1] = raw_i[LEFT];
        map_o.joy[2] = raw_i[DOWN];
        map_o.joy[3] = raw_i[UP];
        map_o.joy[4] = raw_i[B1];
        map_o.joy[5] = raw_i[B2];
        map_o.joy[6] = raw_i[B3];
        map_o.joy[7] = raw_i[B4];
        map_o.joy[8] = raw_i[B5];
        map_o.joy[9] = raw_i[B6];
        map_o.start  = raw_i[START];
        map_o.coin   = raw_i[COIN];
    end

endmodule
`default_nettype wire

// File: rtl/jtframe_db15_joy.sv
`default_nettype none
// ============================================================================
//  Module      : jtframe_db15_joy
//  Description : Serial reader for the DB15 SNAC joystick adapter on the
//                MiSTer user port. Generates the adapter's load and shift
//                clock, shifts in both players' controls (active low on the
//                wire) and presents active-high joystick/coin/start words.
//  Parameters  : CLKDIV  clk_sys cycles per joy_clk half period (>= 2)
//                BITS    bits per scan, 12 per player, player 1 first
//                GAP     idle clk_sys cycles between scans
//  Ports       : clk_sys, RESET (async, active high)
//                mode[1:0]   0 off, 1 one player, 2/3 two players
//                joy_data    serial data from the adapter, active low
//                joy_clk     shift clock to the adapter
//                joy_load    parallel load strobe, active low
//                joy1/joy2   player controls, active high
//                coin/start  {P2, P1}, active high
//                scan_done   one-cycle pulse when outputs are updated
//  Options     : JTFRAME_DB15_FILTER_EN - outputs only load when two
//                consecutive captures agree (glitch rejection)
//  Revision    : 1.0 - initial release
// ============================================================================
module jtframe_db15_joy
    import jtframe_db15_pkg::*;
#(
    parameter int CLKDIV = 16,
    parameter int BITS   = 24,
    parameter int GAP    = 4096
) (
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic [1:0] mode,
    input  logic       joy_data,
    output logic       joy_clk,
    output logic       joy_load,
    output logic [9:0] joy1,
    output logic [9:0] joy2,
    output logic [1:0] coin,
    output logic [1:0] start,
    output logic       scan_done
);

    // One counter serves the gap, the load pulse and each bit period
    localparam int CNT_MAX = (GAP > 2*CLKDIV) ? GAP : 2*CLKDIV;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = $clog2(BITS);

    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] FULL_LAST  = CNT_W'(2*CLKDIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BITS - 1);

    db15_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [BITS-1:0]  raw_q;        // bit n = n-th bit received, active high
    logic [1:0]       sync_q;
    logic             clk_q;
    logic             load_q;
    logic [9:0]       joy1_q;
    logic [9:0]       joy2_q;
    logic [1:0]       coin_q;
    logic [1:0]       start_q;
    logic             done_q;
`ifdef JTFRAME_DB15_FILTER_EN
    logic [BITS-1:0]  prev_q;       // previous raw capture for agreement test
`endif

    db15_player_t p1_map;
    db15_player_t p2_map;
    logic [9:0]   joy1_d;
    logic [9:0]   joy2_d;
    logic [1:0]   coin_d;
    logic [1:0]   start_d;

    jtframe_db15_map u_map_p1 (
        .raw_i (raw_q[PLAYER_BITS-1:0]),
        .map_o (p1_map)
    );

    jtframe_db15_map u_map_p2 (
        .raw_i (raw_q[2*PLAYER_BITS-1:PLAYER_BITS]),
        .map_o (p2_map)
    );

    // Values loaded at UPDATE; one-player mode hides P2 even though its bits
    // are still shifted in, so switching modes needs no scan realignment.
    always_comb begin
        joy1_d  = p1_map.joy;
        joy2_d  = p2_map.joy;
        coin_d  = {p2_map.coin,  p1_map.coin};
        start_d = {p2_map.start, p1_map.start};
        if (mode == 2'd1) begin
            joy2_d     = '0;
            coin_d[1]  = 1'b0;
            start_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            raw_q   <= '0;
            sync_q  <= 2'b11;
            clk_q   <= 1'b1;
            load_q  <= 1'b1;
            joy1_q  <= '0;
            joy2_q  <= '0;
            coin_q  <= '0;
            start_q <= '0;
            done_q  <= 1'b0;
`ifdef JTFRAME_DB15_FILTER_EN
            prev_q  <= '0;
`endif
        end else begin
            sync_q <= {sync_q[0], joy_data};
            done_q <= 1'b0;
            if (mode == 2'd0) begin
                // Reader disabled: abandon any scan and clear everything
                state_q <= IDLE;
                cnt_q   <= '0;
                idx_q   <= '0;
                clk_q   <= 1'b1;
                load_q  <= 1'b1;
                joy1_q  <= '0;
                joy2_q  <= '0;
                coin_q  <= '0;
                start_q <= '0;
`ifdef JTFRAME_DB15_FILTER_EN
                prev_q  <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        clk_q  <= 1'b1;
                        load_q <= 1'b1;
                        if (cnt_q == GAP_LAST) begin
                            cnt_q   <= '0;
                            load_q  <= 1'b0;
                            state_q <= LOAD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    LOAD: begin
                        if (cnt_q == FULL_LAST) begin
                            cnt_q   <= '0;
                            idx_q   <= '0;
                            load_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SHIFT: begin
                        // First half: clock high, sample at its end. Second
                        // half: clock low, except after the final bit where
                        // no further advance of the adapter is wanted.
                        if (cnt_q == HALF_LAST) begin
                            raw_q <= {~sync_q[1], raw_q[BITS-1:1]};
                            if (idx_q != IDX_LAST) begin
                                clk_q <= 1'b0;
                            end
                        end
                        if (cnt_q == FULL_LAST) begin
                            cnt_q <= '0;
                            clk_q <= 1'b1;
                            if (idx_q == IDX_LAST) begin
                                state_q <= UPDATE;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    UPDATE: begin
`ifdef JTFRAME_DB15_FILTER_EN
                        prev_q <= raw_q;
                        if (raw_q == prev_q) begin
                            joy1_q  <= joy1_d;
                            joy2_q  <= joy2_d;
                            coin_q  <= coin_d;
                            start_q <= start_d;
                            done_q  <= 1'b1;
                        end
`else
                        joy1_q  <= joy1_d;
                        joy2_q  <= joy2_d;
                        coin_q  <= coin_d;
                        start_q <= start_d;
                        done_q  <= 1'b1;
`endif
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign joy_clk   = clk_q;
    assign joy_load  = load_q;
    assign joy1      = joy1_q;
    assign joy2      = joy2_q;
    assign coin      = coin_q;
    assign start     = start_q;
    assign scan_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_db15_joy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtframe_db15_joy
//  Description : Self-checking bench for jtframe_db15_joy. Models the DB15
//                adapter's shift register, applies a table of hand-computed
//                vectors plus random ones predicted by a behavioural model,
//                and exercises abort, reset-mid-scan and scan timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtframe_db15_joy;

    localparam int CLKDIV     = 4;
    localparam int BITS       = 24;
    localparam int GAP        = 100;
    localparam int PERIOD     = (2 + 2*BITS)*CLKDIV + GAP + 1;
    localparam int DEF_PERIOD = 4897;
`ifdef JTFRAME_DB15_FILTER_EN
    localparam int NEW_SCANS  = 2;
`else
    localparam int NEW_SCANS  = 1;
`endif

    typedef struct {
        logic [1:0]  m;
        logic [11:0] p1;   // pressed mask, bit n = n-th serial position
        logic [11:0] p2;
        logic [9:0]  j1;
        logic [9:0]  j2;
        logic [1:0]  c;
        logic [1:0]  s;
    } vec_t;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic [1:0]  mode    = 2'd2;
    logic        joy_data;
    logic        joy_clk, joy_load, scan_done;
    logic [9:0]  joy1, joy2;
    logic [1:0]  coin, start;

    logic [1:0]  mode_def = 2'd2;
    logic        data_def = 1'b1;
    logic        d_clk, d_load, d_done;
    logic [9:0]  d_joy1, d_joy2;
    logic [1:0]  d_coin, d_start;

    logic [23:0] wire_pat = '1;   // wire levels presented to the adapter
    logic [23:0] ash      = '1;   // adapter shift register

    int tests = 0;
    int fails = 0;

    always #5 clk_sys = ~clk_sys;

    // Adapter: parallel load while load is low, advance on falling clock
    always @(negedge joy_load or negedge joy_clk) begin
        if (!joy_load) ash = wire_pat;
        else           ash = {1'b1, ash[23:1]};
    end
    assign joy_data = ash[0];

    jtframe_db15_joy #(.CLKDIV(CLKDIV), .BITS(BITS), .GAP(GAP)) u_dut (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .mode      (mode),
        .joy_data  (joy_data),
        .joy_clk   (joy_clk),
        .joy_load  (joy_load),
        .joy1      (joy1),
        .joy2      (joy2),
        .coin      (coin),
        .start     (start),
        .scan_done (scan_done)
    );

    jtframe_db15_joy u_def (
        .clk_sys   (clk_sys),
        .RESET     (RESET),
        .mode      (mode_def),
        .joy_data  (data_def),
        .joy_clk   (d_clk),
        .joy_load  (d_load),
        .joy1      (d_joy1),
        .joy2      (d_joy2),
        .coin      (d_coin),
        .start     (d_start),
        .scan_done (d_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for a scan_done pulse, sampling on falling edges
    task automatic wait_done(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit) begin
            @(negedge clk_sys);
            n++;
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: position of the serial bit feeding each joy output bit
    function automatic vec_t predict(input logic [1:0] m, input logic [11:0] p1, input logic [11:0] p2);
        int   src [10] = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 9};
        vec_t r;
        r.m = m; r.p1 = p1; r.p2 = p2;
        for (int j = 0; j < 10; j++) begin
            r.j1[j] = p1[src[j]];
            r.j2[j] = p2[src[j]];
        end
        r.c = {p2[11], p1[11]};
        r.s = {p2[10], p1[10]};
        if (m == 2'd1) begin
            r.j2   = '0;
            r.c[1] = 1'b0;
            r.s[1] = 1'b0;
        end
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        int n;
        bit ok;
        wire_pat = ~{v.p2, v.p1};
        mode     = v.m;
        wait_done(4*PERIOD, n, ok);
        check({tag, "_done"}, 32'(ok), 32'd1);
        check({tag, "_joy1"}, 32'(joy1), 32'(v.j1));
        check({tag, "_joy2"}, 32'(joy2), 32'(v.j2));
        check({tag, "_coin"}, 32'(coin), 32'(v.c));
        check({tag, "_start"}, 32'(start), 32'(v.s));
    endtask

    initial begin
        #700000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [6];
        vec_t rv;
        int   n, cnt;
        bit   ok;

        vt[0] = '{m:2'd2, p1:12'h008, p2:12'h000, j1:10'h001, j2:10'h000, c:2'b00, s:2'b00};
        vt[1] = '{m:2'd2, p1:12'h000, p2:12'h810, j1:10'h000, j2:10'h010, c:2'b10, s:2'b00};
        vt[2] = '{m:2'd1, p1:12'h000, p2:12'h400, j1:10'h000, j2:10'h000, c:2'b00, s:2'b00};
        vt[3] = '{m:2'd2, p1:12'h000, p2:12'h400, j1:10'h000, j2:10'h000, c:2'b00, s:2'b10};
        vt[4] = '{m:2'd3, p1:12'hA01, p2:12'h004, j1:10'h208, j2:10'h002, c:2'b01, s:2'b00};
        vt[5] = '{m:2'd1, p1:12'hFFF, p2:12'hFFF, j1:10'h3FF, j2:10'h000, c:2'b01, s:2'b01};

        // Reset state
        wire_pat = ~{vt[0].p2, vt[0].p1};
        repeat (3) @(negedge clk_sys);
        check("rst_joy1", 32'(joy1), 32'd0);
        check("rst_joy2", 32'(joy2), 32'd0);
        check("rst_coin", 32'(coin), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_done", 32'(scan_done), 32'd0);
        check("rst_clk", 32'(joy_clk), 32'd1);
        check("rst_load", 32'(joy_load), 32'd1);
        RESET = 1'b0;

        // Scan period with default parameters
        cnt = 0;
        while (!d_done && cnt < 2*DEF_PERIOD) begin @(negedge clk_sys); cnt++; end
        check("def_first_done", 32'(d_done), 32'd1);
        cnt = 0;
        do begin @(negedge clk_sys); cnt++; end while (!d_done && cnt < 2*DEF_PERIOD);
        check("def_period", 32'(cnt), 32'(DEF_PERIOD));

        // Table vectors
        for (int i = 0; i < 6; i++) apply(vt[i], $sformatf("vec%0d", i));

        // Scan-to-scan period with unchanged inputs
        wait_done(2*PERIOD, n, ok);
        check("period", 32'(n), 32'(PERIOD));

        // Random vectors against the reference model
        for (int i = 0; i < 12; i++) begin
            rv = predict(2'($urandom_range(1, 3)), 12'($urandom), 12'($urandom));
            apply(rv, $sformatf("rnd%0d", i));
        end

        // Abort mid-shift with mode 0
        apply(predict(2'd2, 12'h0F1, 12'h000), "pre_abort");
        check("pre_abort_nz", 32'(joy1), 32'h0F8);
        cnt = 0;
        while (joy_load && cnt < 4*PERIOD) begin @(negedge clk_sys); cnt++; end
        while (!joy_load && cnt < 4*PERIOD) begin @(negedge clk_sys); cnt++; end
        for (int k = 0; k < 8 && cnt < 4*PERIOD; k++) begin
            while (!joy_clk && cnt < 4*PERIOD) begin @(negedge clk_sys); cnt++; end
            while (joy_clk && cnt < 4*PERIOD) begin @(negedge clk_sys); cnt++; end
        end
        check("abort_reach_bit7", 32'(cnt < 4*PERIOD), 32'd1);
        mode = 2'd0;
        @(posedge clk_sys); #1;
        check("abort_joy1", 32'(joy1), 32'd0);
        check("abort_coin", 32'(coin), 32'd0);
        check("abort_clk", 32'(joy_clk), 32'd1);
        check("abort_load", 32'(joy_load), 32'd1);
        cnt = 0;
        for (int k = 0; k < 2*PERIOD; k++) begin
            @(negedge clk_sys);
            if (scan_done || !joy_load) cnt++;
        end
        check("abort_quiet", 32'(cnt), 32'd0);
        mode = 2'd2;
        wait_done(4*PERIOD, n, ok);
        check("restart_time", 32'(n), 32'(NEW_SCANS*PERIOD));
        check("restart_joy1", 32'(joy1), 32'h0F8);

        // Reset asserted during LOAD
        cnt = 0;
        while (joy_load && cnt < 2*PERIOD) begin @(negedge clk_sys); cnt++; end
        repeat (3) @(negedge clk_sys);
        RESET = 1'b1;
        #1;
        check("rstload_load", 32'(joy_load), 32'd1);
        check("rstload_joy1", 32'(joy1), 32'd0);
        @(negedge clk_sys);
        RESET = 1'b0;
        wait_done(4*PERIOD, n, ok);
        check("rstload_resume", 32'(ok), 32'd1);
        check("rstload_joy1_back", 32'(joy1), 32'h0F8);

`ifdef JTFRAME_DB15_FILTER_EN
        // One-scan glitch on P1 up is rejected
        apply(predict(2'd2, 12'h0F0, 12'h000), "filt_base");
        wire_pat = ~{12'h000, 12'h0F1};
        cnt = 0;
        while (joy_load && cnt < 2*PERIOD) begin @(negedge clk_sys); cnt++; end
        while (!joy_load && cnt < 2*PERIOD) begin @(negedge clk_sys); cnt++; end
        wire_pat = ~{12'h000, 12'h0F0};
        wait_done(5*PERIOD, n, ok);
        check("glitch_done", 32'(ok), 32'd1);
        check("glitch_joy1", 32'(joy1), 32'h0F0);
        // Press held for two scans is accepted
        wire_pat = ~{12'h000, 12'h0F1};
        wait_done(4*PERIOD, n, ok);
        check("held_time", 32'(n), 32'(2*PERIOD));
        check("held_up", 32'(joy1[3]), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
